uart_rx_oversampled: RTL

UART receiver that deserialises an asynchronous serial line into parallel bytes using the 16x oversampling tick from the baud rate generator. It sits directly downstream of the baud rate generator: its `s_tick` input is that generator's `tick` output. It holds each received word in a one-entry output register with a valid/read handshake, and flags framing and overrun errors.

---
 rtl/uart_rx_oversampled.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with one-entry output register
// Frames are timed in s_tick units; data bits are sampled at their centres, LSB first.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int S_W = (STOP_TICKS > 16) ? 5 : 4;
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_START_MID = S_W'(7);
  localparam logic [S_W-1:0] S_BIT_END   = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_END  = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 rx_meta_q, rx_s_q;

  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;

    unique case (state_q)
      // Start detection is deliberately not tick-gated to minimise sampling skew.
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_START_MID) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d     = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_END) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A read landing on the completion cycle consumes the old word, so no overrun.
  always_comb begin
    dout_d      = dout_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (frame_done) begin
      dout_d      = shreg_q;
      rx_valid_d  = 1'b1;
      frame_err_d = ~rx_s_q;
      overrun_d   = rx_valid_q & ~rd;
    end else if (rd && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  assign dout      = dout_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
